// File: rtl/dequantization_if.sv
// Sample/calibration bus for the dequantization block.
// The master drives samples and calibration requests; the slave returns results and status.
interface dequantization_if;
  logic               start_calib;
  logic [31:0]        max_abs;
  logic signed [7:0]  data_in;
  logic               data_valid;
  logic signed [31:0] data_out;
  logic               data_valid_out;
  logic               calib_busy;
  logic               calib_ready;
  logic               data_ready;
  logic [31:0]        scale;

  modport master (
    output start_calib, max_abs, data_in, data_valid,
    input  data_out, data_valid_out, calib_busy, calib_ready, data_ready, scale
  );

  modport slave (
    input  start_calib, max_abs, data_in, data_valid,
    output data_out, data_valid_out, calib_busy, calib_ready, data_ready, scale
  );
endinterface

// File: rtl/dequantization.sv
// int8 -> int32 dequantizer: calibrates a Q24.8 scale = (max_abs<<8)/QMAX with a serial
// restoring divider, then streams data_in*scale>>8. DEQUANT_ROUND_EN selects round-half-up.
module dequantization #(
  parameter int QMAX      = 127,
  parameter int FRAC_BITS = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  dequantization_if.slave bus
);

  localparam int DIV_W  = 32 + FRAC_BITS;
  localparam int CNT_W  = $clog2(DIV_W + 1);
  localparam int PROD_W = 33 + 8;
  localparam logic [32:0] QMAX_W = 33'(QMAX);
`ifdef DEQUANT_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_OFS = PROD_W'(2 ** (FRAC_BITS - 1));
`else
  localparam logic signed [PROD_W-1:0] ROUND_OFS = '0;
`endif

  typedef enum logic [1:0] {IDLE, CALIB, READY} state_t;

  state_t                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [31:0]               rem_q, rem_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [31:0]               scale_q, scale_d;
  logic                      calib_ready_q, calib_ready_d;
  logic                      s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0]  s1_prod_q, s1_prod_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [31:0]        data_out_q, data_out_d;

  logic                      accept_calib;
  logic [32:0]               trial;
  logic                      q_bit;
  logic [31:0]               quot_sat;
  logic signed [PROD_W-1:0]  rounded;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    scale_d       = scale_q;
    calib_ready_d = calib_ready_q;
    accept_calib  = bus.start_calib && (state_q != CALIB);
    trial         = {rem_q, div_q[DIV_W-1]};
    q_bit         = (trial >= QMAX_W);
    quot_sat      = (|div_q[DIV_W-1:32]) ? 32'hFFFF_FFFF : div_q[31:0];

    case (state_q)
      IDLE: begin
        if (bus.start_calib) state_d = CALIB;
      end
      CALIB: begin
        if (cnt_q == CNT_W'(DIV_W)) begin
          scale_d       = quot_sat;
          calib_ready_d = 1'b1;
          state_d       = READY;
        end else begin
          // Dividend bits shift out the top while quotient bits fill in from the bottom.
          rem_d = q_bit ? 32'(trial - QMAX_W) : trial[31:0];
          div_d = {div_q[DIV_W-2:0], q_bit};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        if (bus.start_calib) state_d = CALIB;
      end
      default: state_d = IDLE;
    endcase

    // The dividend register doubles as the latched calibration range.
    if (accept_calib) begin
      div_d         = {bus.max_abs, {FRAC_BITS{1'b0}}};
      rem_d         = '0;
      cnt_d         = '0;
      calib_ready_d = 1'b0;
    end
  end

  always_comb begin
    s1_valid_d  = bus.data_valid && (state_q == READY);
    s1_prod_d   = s1_prod_q;
    if (s1_valid_d)
      s1_prod_d = PROD_W'($signed(bus.data_in)) * PROD_W'($signed({1'b0, scale_q}));
    out_valid_d = s1_valid_q;
    rounded     = s1_prod_q + ROUND_OFS;
    data_out_d  = data_out_q;
    if (s1_valid_q)
      data_out_d = 32'(rounded >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      scale_q       <= '0;
      calib_ready_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_prod_q     <= '0;
      out_valid_q   <= 1'b0;
      data_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      scale_q       <= scale_d;
      calib_ready_q <= calib_ready_d;
      s1_valid_q    <= s1_valid_d;
      s1_prod_q     <= s1_prod_d;
      out_valid_q   <= out_valid_d;
      data_out_q    <= data_out_d;
    end
  end

  assign bus.calib_busy     = (state_q == CALIB);
  assign bus.data_ready     = (state_q == READY);
  assign bus.calib_ready    = calib_ready_q;
  assign bus.scale          = scale_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_valid_out = out_valid_q;

endmodule

// File: tb/tb_dequantization.sv
// Directed bench for dequantization: calibration timing, scale values, sample latency,
// streaming, in-flight recalibration and mid-calibration reset.
module tb_dequantization;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dequantization_if dif ();

  dequantization #(.QMAX(127), .FRAC_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif)
  );

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DEQUANT_ROUND_EN
  localparam logic [31:0] EXP_M3     = 32'hFFFF_FFFE;  // -2
  localparam logic [31:0] EXP_SAT_LO = 32'h8000_0001;  // -2147483647
  localparam logic [31:0] EXP_SAT_HI = 32'd2130706432;
`else
  localparam logic [31:0] EXP_M3     = 32'hFFFF_FFFD;  // -3
  localparam logic [31:0] EXP_SAT_LO = 32'h8000_0000;  // -2147483648
  localparam logic [31:0] EXP_SAT_HI = 32'd2130706431;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end else begin
      $display("ok   %s = %0d (0x%08h)", tag, $signed(got), got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_calib(input logic [31:0] m, input logic [31:0] old_scale, output int cycles);
    dif.max_abs     = m;
    dif.start_calib = 1'b1;
    tick();
    dif.start_calib = 1'b0;
    cycles = 0;
    while (dif.calib_busy && cycles < 200) begin
      cycles++;
      if (cycles == 1)  check_eq("calib_ready_clr", 32'(dif.calib_ready), 32'd0);
      if (cycles == 20) check_eq("scale_hold", dif.scale, old_scale);
      tick();
    end
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic [31:0] exp);
    dif.data_in    = d;
    dif.data_valid = 1'b1;
    tick();
    dif.data_valid = 1'b0;
    check_eq({tag, "_lat1_vld"}, 32'(dif.data_valid_out), 32'd0);
    tick();
    check_eq({tag, "_vld"}, 32'(dif.data_valid_out), 32'd1);
    check_eq(tag, dif.data_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int ready_seen;
    int stray;

    dif.start_calib = 1'b0;
    dif.max_abs     = '0;
    dif.data_in     = '0;
    dif.data_valid  = 1'b0;

    repeat (3) tick();
    check_eq("rst_scale", dif.scale, 32'd0);
    check_eq("rst_calib_ready", 32'(dif.calib_ready), 32'd0);
    check_eq("rst_busy", 32'(dif.calib_busy), 32'd0);
    check_eq("rst_data_ready", 32'(dif.data_ready), 32'd0);
    check_eq("rst_vld_out", 32'(dif.data_valid_out), 32'd0);
    check_eq("rst_data_out", dif.data_out, 32'd0);
    reset_n = 1'b1;

    // Samples offered while IDLE must be dropped.
    dif.data_valid = 1'b1;
    dif.data_in    = 8'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("idle_drop_vld", 32'(dif.data_valid_out), 32'd0);
    end
    dif.data_valid = 1'b0;
    tick();
    check_eq("idle_drop_vld", 32'(dif.data_valid_out), 32'd0);
    check_eq("idle_drop_out", dif.data_out, 32'd0);

    do_calib(32'd127, 32'd0, cyc);
    check_eq("c127_busy_cycles", 32'(cyc), 32'd41);
    check_eq("c127_scale", dif.scale, 32'd256);
    check_eq("c127_calib_ready", 32'(dif.calib_ready), 32'd1);
    check_eq("c127_data_ready", 32'(dif.data_ready), 32'd1);
    send("c127_m5", 8'hFB, 32'hFFFF_FFFB);

    // Back-to-back stream -128..127 at unity scale.
    for (int i = 0; i < 258; i++) begin
      if (i < 256) begin
        dif.data_valid = 1'b1;
        dif.data_in    = 8'(i - 128);
      end else begin
        dif.data_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 256) begin
        check_eq("stream_vld", 32'(dif.data_valid_out), 32'd1);
        check_eq("stream_out", dif.data_out, 32'(i - 1 - 128));
      end
    end
    check_eq("stream_end_vld", 32'(dif.data_valid_out), 32'd0);
    check_eq("stream_hold_out", dif.data_out, 32'd127);

    do_calib(32'd100, 32'd256, cyc);
    check_eq("c100_busy_cycles", 32'(cyc), 32'd41);
    check_eq("c100_scale", dif.scale, 32'd201);
    send("c100_p3", 8'd3, 32'd2);
    send("c100_m3", 8'hFD, EXP_M3);

    do_calib(32'hFFFF_FFFF, 32'd201, cyc);
    check_eq("cmax_busy_cycles", 32'(cyc), 32'd41);
    check_eq("cmax_scale", dif.scale, 32'hFFFF_FFFF);
    send("cmax_m128", 8'h80, EXP_SAT_LO);
    send("cmax_p127", 8'd127, EXP_SAT_HI);

    do_calib(32'd127, 32'hFFFF_FFFF, cyc);
    check_eq("c127b_scale", dif.scale, 32'd256);

    // Recalibrate from READY with two samples in flight.
    dif.data_in    = 8'd10;
    dif.data_valid = 1'b1;
    tick();
    dif.data_in     = 8'd20;
    dif.max_abs     = 32'd254;
    dif.start_calib = 1'b1;
    tick();
    dif.start_calib = 1'b0;
    dif.data_in     = 8'd55;
    ready_seen = 0;
    stray      = 0;
    cyc        = 0;
    check_eq("inflight0_vld", 32'(dif.data_valid_out), 32'd1);
    check_eq("inflight0_out", dif.data_out, 32'd10);
    if (dif.calib_busy) cyc++;
    if (dif.data_ready) ready_seen++;
    tick();
    check_eq("inflight1_vld", 32'(dif.data_valid_out), 32'd1);
    check_eq("inflight1_out", dif.data_out, 32'd20);
    if (dif.calib_busy) cyc++;
    if (dif.data_ready) ready_seen++;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!dif.calib_busy) break;
      cyc++;
      if (dif.data_ready) ready_seen++;
      if (dif.data_valid_out) stray++;
    end
    dif.data_valid = 1'b0;
    check_eq("c254_busy_cycles", 32'(cyc), 32'd41);
    check_eq("c254_ready_low", 32'(ready_seen), 32'd0);
    check_eq("c254_calib_drop", 32'(stray), 32'd0);
    check_eq("c254_scale", dif.scale, 32'd512);
    send("c254_p127", 8'd127, 32'd254);

    // Asynchronous reset in the middle of a calibration.
    dif.max_abs     = 32'd127;
    dif.start_calib = 1'b1;
    tick();
    dif.start_calib = 1'b0;
    repeat (19) tick();
    check_eq("mid_busy", 32'(dif.calib_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_scale", dif.scale, 32'd0);
    check_eq("arst_calib_ready", 32'(dif.calib_ready), 32'd0);
    check_eq("arst_busy", 32'(dif.calib_busy), 32'd0);
    check_eq("arst_data_ready", 32'(dif.data_ready), 32'd0);
    check_eq("arst_vld_out", 32'(dif.data_valid_out), 32'd0);
    check_eq("arst_data_out", dif.data_out, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_idle", 32'(dif.calib_busy), 32'd0);
    do_calib(32'd127, 32'd0, cyc);
    check_eq("fresh_busy_cycles", 32'(cyc), 32'd41);
    check_eq("fresh_scale", dif.scale, 32'd256);
    check_eq("fresh_calib_ready", 32'(dif.calib_ready), 32'd1);
    send("fresh_m5", 8'hFB, 32'hFFFF_FFFB);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dequantization.md
DEQUANTIZATION -- requirements
Module: dequantization

Interface
REQ-001 SHALL have parameter QMAX, default 127; it is the integer divisor used at calibration (int8 full-scale code).
REQ-002 SHALL have parameter FRAC_BITS, fixed at 8; it is the number of fractional bits of scale (Q24.8).
REQ-003 SHALL have port clk, input, 1, the clock; every register updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port start_calib, input, 1, a calibration request pulse.
REQ-006 SHALL have port max_abs, input, 32, an unsigned calibration range.
REQ-007 SHALL have port data_in, input, 8, a signed int8 sample.
REQ-008 SHALL have port data_valid, input, 1, which qualifies data_in.
REQ-009 SHALL have port data_out, output, 32, the signed int32 dequantized value.
REQ-010 SHALL have port data_valid_out, output, 1, which qualifies data_out.
REQ-011 SHALL have ports calib_busy, calib_ready and data_ready, output, 1 each, as status signals.
REQ-012 SHALL have port scale, output, 32, the committed Q24.8 scale.

Function
REQ-013 SHALL implement FSM states IDLE, CALIB and READY.
- IDLE->CALIB on start_calib.
- CALIB->READY on division done.
- READY->CALIB on start_calib.
REQ-014 SHALL, on the edge that accepts start_calib, latch max_abs, load dividend {max_abs,8'b0} (40 bits), and clear calib_ready.
REQ-015 SHALL ignore start_calib while in CALIB; the running division is neither restarted nor aborted.
REQ-016 SHALL compute the quotient by restoring division with divisor QMAX, one quotient bit per clock, 40 iterations on the 40 edges after the load edge.
REQ-017 SHALL, on the 41st edge after the load edge, commit scale = quotient saturated to 0xFFFFFFFF, set calib_ready=1 and enter READY.
REQ-018 SHALL keep scale unchanged during CALIB until the commit edge.
REQ-019 SHALL drive the status outputs as follows:
- calib_busy = (state==CALIB).
- data_ready = (state==READY).
- calib_ready is registered: set on commit, cleared on accept of start_calib.
REQ-020 SHALL accept a sample only when data_valid && data_ready; data_valid in IDLE or CALIB is dropped and produces no output.
REQ-021 SHALL process each accepted sample in a 2-stage pipeline.
- Stage 1 registers the 41-bit signed product data_in*scale.
- Stage 2 applies the rounding of REQ-030, arithmetic-shifts right by 8, and registers the low 32 bits.
REQ-022 SHALL assert data_out and data_valid_out exactly 2 edges after the accepting edge; throughput is 1 sample/clock and there is no backpressure.
REQ-023 SHALL not need saturation, because |data_in*scale|>>8 < 2^31 for all inputs.
REQ-024 SHALL let in-flight samples complete with the scale they captured at stage 1, even when start_calib is accepted in READY.
REQ-025 SHALL give scale=0 when max_abs=0, so that every data_out=0.
REQ-026 SHALL hold data_out at its last value while data_valid_out=0.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force the following:
- state=IDLE, scale=0, calib_ready=0.
- data_out=0, data_valid_out=0, both pipeline valid bits cleared.
- divider registers cleared.
REQ-028 SHALL, when reset is asserted mid-calibration, abandon the division; the next start_calib after release starts a fresh 41-cycle calibration.
REQ-029 SHALL treat reset release as synchronous to clk; the first start_calib is sampled on the first edge after release.

Configuration
REQ-030 SHALL select stage-2 rounding with macro DEQUANT_ROUND_EN.
- Defined: add 128 before the shift (round half up).
- Undefined: no offset is added (truncate toward negative infinity).

Verification
REQ-031 SHALL cover: max_abs=127, start_calib -> calib_busy for 41 cycles, then scale=256 and calib_ready=1; data_in=-5 -> data_out=-5 two cycles later.
REQ-032 SHALL cover: max_abs=100 -> scale=201.
- Rounding build: data_in=3 -> 2, data_in=-3 -> -2.
- Truncation build: data_in=3 -> 2, data_in=-3 -> -3.
REQ-033 SHALL cover: max_abs=0xFFFFFFFF -> scale=0xFFFFFFFF (saturated); data_in=-128 -> -2147483647 (rounding build) / -2147483648 (truncation build).
REQ-034 SHALL cover: back-to-back stream of data_in=-128..127 at max_abs=127 -> 256 consecutive valid outputs equal to the inputs; data_valid in IDLE -> no data_valid_out.
REQ-035 SHALL cover: start_calib (max_abs=254) in READY with 2 samples in flight -> both samples use the old scale; data_ready=0 for 41 cycles; then scale=512 and data_in=127 -> 254.
REQ-036 SHALL cover: reset_n pulse at cycle 20 of calibration -> all outputs 0, state IDLE; a fresh start_calib completes normally.
